hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// Detects load-use hazards between EX and ID, sequences branch redirects
// resolved in EX, and holds the pipeline while data memory is busy.
// A taken branch that arrives while the pipeline is held is remembered and
// replayed as a redirect once memory becomes ready again.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add two saturating
// performance counters (stall_cycles, flush_count).
//
// Parameters
//   ADDR_W  width of branch target / redirect address (instruction words)
//   REG_W   width of register-index fields
//   CNT_W   width of each performance counter
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   id_valid        ID stage holds a valid instruction
//   id_rs1, id_rs2  ID source register indices
//   id_use_rs2      ID instruction reads rs2
//   ex_mem_read     EX instruction is a load
//   ex_rd           EX destination register
//   ex_br_taken     EX resolved a taken branch
//   ex_br_target    target of that branch
//   mem_busy        data memory not ready, pipeline must hold
//   stall           hold PC and IF/ID
//   branch_addr     redirect target, zero when no redirect
//   redirect_valid  branch_addr is valid this cycle
//   flush_if_id     bubble the IF/ID register
//   flush_id_ex     bubble the ID/EX register
//   stall_cycles    (HAZARD_PERF_CNT_EN) cycles with stall=1, saturating
//   flush_count     (HAZARD_PERF_CNT_EN) redirect cycles, saturating
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              mem_busy,
  output logic              stall,
  output logic [ADDR_W-1:0] branch_addr,
  output logic              redirect_valid,
  output logic              flush_if_id,
  output logic              flush_id_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    MWAIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic               r_pending;
  logic               w_pendingNext;
  logic [ADDR_W-1:0]  r_target;
  logic [ADDR_W-1:0]  w_targetNext;

  logic               w_loadUse;
  logic               w_stall;
  logic               w_redirect;
  logic               w_flushIfId;
  logic               w_flushIdEx;
  logic [ADDR_W-1:0]  w_branchAddr;

  // Register x0 is hard-wired to zero, so a load targeting it never creates
  // a real dependency.
  assign w_loadUse = id_valid && ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_pending <= 1'b0;
      r_target  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_pending <= w_pendingNext;
      r_target  <= w_targetNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_pendingNext = r_pending;
    w_targetNext  = r_target;
    w_stall       = 1'b0;
    w_redirect    = 1'b0;
    w_flushIfId   = 1'b0;
    w_flushIdEx   = 1'b0;
    w_branchAddr  = '0;

    case (r_state)
      RUN: begin
        // Branch outranks memory, which outranks load-use. A branch that
        // coincides with a busy memory is parked as pending so the redirect
        // happens only after the hold is released.
        if (ex_br_taken) begin
          w_targetNext = ex_br_target;
          if (mem_busy) begin
            w_stall       = 1'b1;
            w_pendingNext = 1'b1;
            w_stateNext   = MWAIT;
          end else begin
            w_stateNext = REDIR;
          end
        end else if (mem_busy) begin
          w_stall     = 1'b1;
          w_stateNext = MWAIT;
        end else if (w_loadUse) begin
          w_stall     = 1'b1;
          w_flushIdEx = 1'b1;
        end
      end

      REDIR: begin
        // ID is being flushed, so load-use detection is deliberately ignored.
        w_redirect    = 1'b1;
        w_branchAddr  = r_target;
        w_flushIfId   = 1'b1;
        w_flushIdEx   = 1'b1;
        w_pendingNext = 1'b0;
        w_stateNext   = RUN;
      end

      MWAIT: begin
        // A branch seen on the release cycle itself still leads to REDIR.
        if (ex_br_taken) begin
          w_targetNext  = ex_br_target;
          w_pendingNext = 1'b1;
        end
        if (mem_busy) begin
          w_stall = 1'b1;
        end else begin
          w_pendingNext = 1'b0;
          w_stateNext   = (r_pending || ex_br_taken) ? REDIR : RUN;
        end
      end

      default: begin
        w_stateNext = RUN;
      end
    endcase
  end

  // Outputs are gated by rst_n so that asserting reset silences everything
  // immediately, including combinational load-use and memory stalls.
  assign stall          = rst_n & w_stall;
  assign redirect_valid = rst_n & w_redirect;
  assign flush_if_id    = rst_n & w_flushIfId;
  assign flush_id_ex    = rst_n & w_flushIdEx;
  assign branch_addr    = rst_n ? w_branchAddr : '0;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      if (w_stall && (r_stallCycles != '1)) begin
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
      if (w_redirect && (r_flushCount != '1)) begin
        r_flushCount <= r_flushCount + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_count  = r_flushCount;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Directed scenarios cover load-use,
// branch redirect, zero target, memory wait with a parked branch and reset
// during a redirect; a randomized run is checked cycle by cycle against a
// behavioural model that tracks "memory hold active", "redirect due this
// cycle" and "branch waiting for the hold to end".
// Counters are exercised when HAZARD_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic              id_use_rs2;
  logic              ex_mem_read;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_br_taken;
  logic [ADDR_W-1:0] ex_br_target;
  logic              mem_busy;
  logic              stall;
  logic [ADDR_W-1:0] branch_addr;
  logic              redirect_valid;
  logic              flush_if_id;
  logic              flush_id_ex;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;
`endif

  hazard_ctrl #(
    .ADDR_W(ADDR_W),
    .REG_W (REG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs2    (id_use_rs2),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_br_taken   (ex_br_taken),
    .ex_br_target  (ex_br_target),
    .mem_busy      (mem_busy),
    .stall         (stall),
    .branch_addr   (branch_addr),
    .redirect_valid(redirect_valid),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall, redirect_valid, flush_if_id, flush_id_ex, branch_addr}
  logic [35:0] obsOut;
  assign obsOut = {stall, redirect_valid, flush_if_id, flush_id_ex, branch_addr};

  int nTotal = 0;
  int nBad   = 0;

  // Behavioural model state
  bit          mWait;
  bit          mRedir;
  bit          mHave;
  logic [31:0] mTgt;
  int          expStall;
  int          expFlush;

  task automatic resetModel();
    mWait    = 0;
    mRedir   = 0;
    mHave    = 0;
    mTgt     = '0;
    expStall = 0;
    expFlush = 0;
  endtask

  function automatic logic [35:0] expOut();
    logic lu;
    if (!rst_n) return '0;
    if (mRedir) return {1'b0, 1'b1, 1'b1, 1'b1, mTgt};
    lu = id_valid && ex_mem_read && (ex_rd != 0) &&
         ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
    if (mWait)       return {mem_busy, 35'b0};
    if (ex_br_taken) return {mem_busy, 35'b0};
    if (mem_busy)    return {1'b1, 35'b0};
    if (lu)          return {1'b1, 1'b0, 1'b0, 1'b1, 32'b0};
    return '0;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic advance();
    logic [35:0] e;
    e = expOut();
    if (!rst_n) begin
      resetModel();
    end else begin
      if (e[35] && expStall != CNT_MAX) expStall++;
      if (e[34] && expFlush != CNT_MAX) expFlush++;
      if (mRedir) begin
        mRedir = 0;
      end else begin
        if (ex_br_taken) begin
          mTgt  = ex_br_target;
          mHave = 1;
        end
        if (mWait) begin
          if (!mem_busy) begin
            mWait  = 0;
            mRedir = mHave;
            mHave  = 0;
          end
        end else if (ex_br_taken) begin
          if (mem_busy) begin
            mWait = 1;
          end else begin
            mRedir = 1;
            mHave  = 0;
          end
        end else if (mem_busy) begin
          mWait = 1;
        end
      end
    end
  endtask

  task automatic tick();
    advance();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u2, input logic mr, input logic [4:0] rd,
                       input logic br, input logic [31:0] t, input logic busy);
    id_valid     = v;
    id_rs1       = r1;
    id_rs2       = r2;
    id_use_rs2   = u2;
    ex_mem_read  = mr;
    ex_rd        = rd;
    ex_br_taken  = br;
    ex_br_target = t;
    mem_busy     = busy;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    resetModel();
    drive(1, 5, 0, 0, 1, 5, 0, 32'h0, 1);
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL reset_outputs: got %h want %h", obsOut, 36'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL reset_release: got %h want %h", obsOut, 36'h0);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(1, 5, 0, 0, 1, 5, 0, 32'h0, 0);
    nTotal++;
    if (obsOut !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h0}) begin
      nBad++;
      $display("[TB] FAIL loaduse_rs1: got %h want %h", obsOut, {1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    end
    tick();
    drive(1, 3, 7, 1, 1, 7, 0, 32'h0, 0);
    nTotal++;
    if (obsOut !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h0}) begin
      nBad++;
      $display("[TB] FAIL loaduse_rs2: got %h want %h", obsOut, {1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    end
    tick();
    drive(1, 3, 7, 0, 1, 7, 0, 32'h0, 0);
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL loaduse_rs2_unused: got %h want %h", obsOut, 36'h0);
    end
    tick();
    drive(1, 0, 0, 1, 1, 0, 0, 32'h0, 0);
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL loaduse_x0: got %h want %h", obsOut, 36'h0);
    end
    tick();
    drive(0, 5, 0, 0, 1, 5, 0, 32'h0, 0);
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL loaduse_invalid: got %h want %h", obsOut, 36'h0);
    end
    tick();
  endtask

  task automatic test_branch();
    // Branch with a coincident load-use: branch wins, no stall.
    drive(1, 5, 0, 0, 1, 5, 1, 32'h40, 0);
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL branch_issue: got %h want %h", obsOut, 36'h0);
    end
    tick();
    // Load-use present during REDIR is suppressed.
    drive(1, 5, 0, 0, 1, 5, 0, 32'h0, 0);
    nTotal++;
    if (obsOut !== {1'b0, 1'b1, 1'b1, 1'b1, 32'h40}) begin
      nBad++;
      $display("[TB] FAIL branch_redir: got %h want %h", obsOut, {1'b0, 1'b1, 1'b1, 1'b1, 32'h40});
    end
    tick();
    idle();
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL branch_after: got %h want %h", obsOut, 36'h0);
    end
    tick();
  endtask

  task automatic test_zero_target();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    tick();
    idle();
    nTotal++;
    if (obsOut !== {1'b0, 1'b1, 1'b1, 1'b1, 32'h0}) begin
      nBad++;
      $display("[TB] FAIL zero_target: got %h want %h", obsOut, {1'b0, 1'b1, 1'b1, 1'b1, 32'h0});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0, 0, (c == 1), 32'h80, 1);
      nTotal++;
      if (obsOut !== {1'b1, 35'b0}) begin
        nBad++;
        $display("[TB] FAIL memwait_stall%0d: got %h want %h", c, obsOut, {1'b1, 35'b0});
      end
      tick();
    end
    idle();
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL memwait_release: got %h want %h", obsOut, 36'h0);
    end
    tick();
    nTotal++;
    if (obsOut !== {1'b0, 1'b1, 1'b1, 1'b1, 32'h80}) begin
      nBad++;
      $display("[TB] FAIL memwait_redir: got %h want %h", obsOut, {1'b0, 1'b1, 1'b1, 1'b1, 32'h80});
    end
    tick();
    // Branch and busy together in RUN: hold first, redirect after release.
    drive(0, 0, 0, 0, 0, 0, 1, 32'hC0, 1);
    nTotal++;
    if (obsOut !== {1'b1, 35'b0}) begin
      nBad++;
      $display("[TB] FAIL br_busy_stall: got %h want %h", obsOut, {1'b1, 35'b0});
    end
    tick();
    idle();
    tick();
    nTotal++;
    if (obsOut !== {1'b0, 1'b1, 1'b1, 1'b1, 32'hC0}) begin
      nBad++;
      $display("[TB] FAIL br_busy_redir: got %h want %h", obsOut, {1'b0, 1'b1, 1'b1, 1'b1, 32'hC0});
    end
    tick();
  endtask

  task automatic test_reset_mid_redir();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h1234, 0);
    tick();
    idle();
    nTotal++;
    if (obsOut !== {1'b0, 1'b1, 1'b1, 1'b1, 32'h1234}) begin
      nBad++;
      $display("[TB] FAIL midredir_pre: got %h want %h", obsOut, {1'b0, 1'b1, 1'b1, 1'b1, 32'h1234});
    end
    rst_n = 1'b0;
    resetModel();
    #1;
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL midredir_async: got %h want %h", obsOut, 36'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL midredir_release: got %h want %h", obsOut, 36'h0);
    end
    tick();
    nTotal++;
    if (obsOut !== 36'h0) begin
      nBad++;
      $display("[TB] FAIL midredir_norun: got %h want %h", obsOut, 36'h0);
    end
    tick();
  endtask

  task automatic test_random();
    logic [35:0] e;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 5) == 0), $urandom, 1'($urandom_range(0, 3) == 0));
      e = expOut();
      nTotal++;
      if (obsOut !== e) begin
        nBad++;
        $display("[TB] FAIL random_cycle%0d: got %h want %h", c, obsOut, e);
      end
      tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    nTotal++;
    if (stall_cycles !== CNT_W'(expStall)) begin
      nBad++;
      $display("[TB] FAIL random_stall_cnt: got %0d want %0d", stall_cycles, expStall);
    end
    nTotal++;
    if (flush_count !== CNT_W'(expFlush)) begin
      nBad++;
      $display("[TB] FAIL random_flush_cnt: got %0d want %0d", flush_count, expFlush);
    end
`endif
    idle();
    for (int c = 0; c < 4; c++) tick();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_counters();
    rst_n = 1'b0;
    resetModel();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
      tick();
    end
    idle();
    tick();
    for (int r = 0; r < 2; r++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 32'h10, 0);
      tick();
      idle();
      tick();
    end
    nTotal++;
    if (stall_cycles !== CNT_W'(4)) begin
      nBad++;
      $display("[TB] FAIL cnt_stall: got %0d want %0d", stall_cycles, 4);
    end
    nTotal++;
    if (flush_count !== CNT_W'(2)) begin
      nBad++;
      $display("[TB] FAIL cnt_flush: got %0d want %0d", flush_count, 2);
    end
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
      tick();
    end
    nTotal++;
    if (stall_cycles !== CNT_W'(CNT_MAX)) begin
      nBad++;
      $display("[TB] FAIL cnt_saturate: got %0d want %0d", stall_cycles, CNT_MAX);
    end
    idle();
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle();
    resetModel();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_zero_target();
    test_mem_wait();
    test_reset_mid_redir();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
